// File: rtl/valid_ready_level_fifo.sv
// Synchronous valid/ready FIFO with first-word fall-through, occupancy level,
// programmable almost-full/almost-empty flags and a synchronous flush.
module valid_ready_level_fifo #(
    parameter int unsigned WIDTH                  = 8,
    parameter int unsigned DEPTH                  = 4,
    parameter int unsigned ALMOST_FULL_THRESHOLD  = DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           write_data,
    input  logic                       write_valid,
    output logic                       write_ready,
    output logic                       full,
    output logic                       almost_full,
    output logic [WIDTH-1:0]           read_data,
    output logic                       read_valid,
    input  logic                       read_ready,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_nxt;
    logic             do_write;
    logic             do_read;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status flags are decoded from the registered level only.
    assign full         = (level == LVL_W'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LVL_W'(ALMOST_FULL_THRESHOLD));
    assign almost_empty = (level <= LVL_W'(ALMOST_EMPTY_THRESHOLD));

    // Flush blocks both handshakes; write side never looks at read_ready.
    assign write_ready = ~full & ~flush;
    assign read_valid  = ~empty & ~flush;
    assign do_write    = write_valid & write_ready;
    assign do_read     = read_valid & read_ready;

    assign read_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        unique case ({do_write, do_read})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_read) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level <= level_nxt;
        end
    end

    // Storage is intentionally not reset; contents are only observed when read_valid.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr] <= write_data;
        end
    end

endmodule
